// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// watchdog width and a lowest-set-bit priority picker.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    PWR_WAIT = 2'd0,
    DONE     = 2'd1,
    SW_HOLD  = 2'd2
  } state_t;

  localparam int WDG_W  = 16;
  localparam int PRIO_W = 32;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [4:0] lsb_idx(input logic [PRIO_W-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = PRIO_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter with a registered expire flag (count == 1).
// Shared by the release gap and the software-reset hold.
module rst_seq_cnt #(
  parameter int DLY_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [DLY_W-1:0] i_val,
  output logic             o_exp
);

  logic [DLY_W-1:0] r_cnt;
  logic             r_exp;

  // The flag is computed from the next count so it lines up with r_cnt == 1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_exp <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_val;
      r_exp <= (i_val == DLY_W'(1));
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      r_exp <= (r_cnt == DLY_W'(2));
    end else begin
      r_exp <= 1'b0;
    end
  end

  assign o_exp = r_exp;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Power-up / software reset sequencer for NUM_DOM active-low domain resets.
// Optional watchdog re-sequencing is enabled by defining RST_SEQ_WDOG_EN.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM   = 8,
  parameter int DLY_W     = 8,
  parameter int PULSE_MIN = 4,
  parameter int IDX_W     = $clog2(NUM_DOM)
) (
  input  logic               clk,
  input  logic               s_reset,
  input  logic [DLY_W-1:0]   cfg_dly,
  input  logic [NUM_DOM-1:0] sw_rst_req,
`ifdef RST_SEQ_WDOG_EN
  input  logic               wdg_kick,
  output logic               wdg_evt,
`endif
  output logic [NUM_DOM-1:0] rst_n_out,
  output logic               busy,
  output logic               seq_done,
  output logic [IDX_W-1:0]   cur_dom
);

  state_t             r_state;
  logic [NUM_DOM-1:0] r_rst_n;
  logic [NUM_DOM-1:0] r_pend;
  logic [IDX_W-1:0]   r_cur;
  logic               r_busy;
  logic               r_done;
  logic               r_fresh;

  logic [DLY_W-1:0]   w_dly;
  logic               w_exp;
  logic               w_rel;
  logic               w_pick;
  logic [IDX_W-1:0]   w_p;
  logic [NUM_DOM-1:0] w_clr;
  logic               w_load;
  logic [DLY_W-1:0]   w_load_val;
  logic               w_wdg_hit;

  assign w_dly  = (cfg_dly == '0) ? DLY_W'(1) : cfg_dly;
  // First cycle out of reset behaves as if the counter already held w_dly.
  assign w_rel  = r_fresh ? (w_dly == DLY_W'(1)) : w_exp;
  assign w_pick = (r_state == DONE) && (r_pend != '0);
  assign w_p    = IDX_W'(lsb_idx(PRIO_W'(r_pend)));

`ifdef RST_SEQ_WDOG_EN
  logic [WDG_W-1:0] r_wdg;
  logic             r_wdg_evt;
  logic             w_wdg_run;

  assign w_wdg_run = (r_state == DONE) || (r_state == SW_HOLD);
  assign w_wdg_hit = w_wdg_run && !wdg_kick && (r_wdg == {{(WDG_W-1){1'b1}}, 1'b0});

  always_ff @(posedge clk or posedge s_reset) begin
    if (s_reset) begin
      r_wdg     <= '0;
      r_wdg_evt <= 1'b0;
    end else begin
      r_wdg_evt <= w_wdg_hit;
      if (!w_wdg_run || wdg_kick || w_wdg_hit) r_wdg <= '0;
      else                                     r_wdg <= r_wdg + 1'b1;
    end
  end

  assign wdg_evt = r_wdg_evt;
`else
  assign w_wdg_hit = 1'b0;
`endif

  always_comb begin
    w_clr = '0;
    if (w_pick) w_clr[w_p] = 1'b1;
  end

  always_comb begin
    w_load     = 1'b0;
    w_load_val = w_dly;
    if (w_wdg_hit) begin
      w_load = 1'b1;
    end else begin
      case (r_state)
        PWR_WAIT: begin
          if (w_rel) begin
            w_load = 1'b1;
          end else if (r_fresh) begin
            w_load     = 1'b1;
            w_load_val = w_dly - DLY_W'(1);
          end
        end
        DONE: begin
          if (w_pick) begin
            w_load     = 1'b1;
            w_load_val = DLY_W'(PULSE_MIN);
          end
        end
        default: ;
      endcase
    end
  end

  rst_seq_cnt #(.DLY_W(DLY_W)) u_cnt (
    .i_clk  (clk),
    .i_rst  (s_reset),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_exp  (w_exp)
  );

  always_ff @(posedge clk or posedge s_reset) begin
    if (s_reset) begin
      r_state <= PWR_WAIT;
      r_rst_n <= '0;
      r_pend  <= '0;
      r_cur   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_fresh <= 1'b1;
    end else begin
      r_fresh <= 1'b0;
      // Clear before OR so a same-cycle re-request wins.
      r_pend  <= (r_pend & ~w_clr) | sw_rst_req;
      if (w_wdg_hit) begin
        r_state <= PWR_WAIT;
        r_rst_n <= '0;
        r_pend  <= '0;
        r_cur   <= '0;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          PWR_WAIT: begin
            if (w_rel) begin
              r_rst_n[r_cur] <= 1'b1;
              if (r_cur == IDX_W'(NUM_DOM - 1)) begin
                r_state <= DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_cur <= r_cur + 1'b1;
              end
            end
          end
          DONE: begin
            if (w_pick) begin
              r_cur        <= w_p;
              r_rst_n[w_p] <= 1'b0;
              r_state      <= SW_HOLD;
              r_busy       <= 1'b1;
            end
          end
          SW_HOLD: begin
            if (w_exp) begin
              r_rst_n[r_cur] <= 1'b1;
              r_state        <= DONE;
              r_busy         <= 1'b0;
            end
          end
          default: r_state <= PWR_WAIT;
        endcase
      end
    end
  end

  assign rst_n_out = r_rst_n;
  assign busy      = r_busy;
  assign seq_done  = r_done;
  assign cur_dom   = r_cur;

endmodule
